stage1_if: RTL and testbench

Stage 1 of the five cycle MIPS CPU: instruction fetch (IF). It owns the program counter and issues requests to instruction memory over a valid/ready handshake. It registers the fetched word and PC+4 into the IF/ID boundary consumed by `stage2_id`. It accepts a branch redirect from the memory stage and a stall from the hazard logic, and holds one fetched word internally when a fetch completes during a stall.

---
 rtl/stage1_if.sv | 156 +++++++++++++++
 tb/tb_stage1_if.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/stage1_if.sv
// stage1_if: MIPS instruction-fetch stage. Owns the PC, fetches from
// instruction memory over a valid/ready handshake and registers the fetched
// word plus PC+4 into the IF/ID boundary.
// Ports: clk/rst (async active-high); stall, pcsrc/baddr (redirect) control;
// imem_req/imem_addr/imem_ready/imem_rdata fetch handshake;
// inst/pc4/if_valid IF/ID outputs; if_pc exposes the PC register.
module stage1_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic [31:0] baddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc4,
  output logic        if_valid,
  output logic [31:0] if_pc
);

  // RUN: fetching; HOLD: a word was captured during a stall;
  // DROP: waiting out a request that a redirect made stale.
  typedef enum logic [1:0] {RUN, HOLD, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] hbuf_q, hbuf_d;
  logic [31:0] hpc4_q, hpc4_d;
  logic [31:0] rpc_q, rpc_d;

  logic        hs;
  logic [31:0] pc_plus4;

  // The request is combinational on state so reset forces it low at once.
  assign imem_req  = !rst && (state_q != HOLD);
  assign imem_addr = pc_q;
  assign hs        = imem_req && imem_ready;
  assign pc_plus4  = pc_q + 32'd4;

  assign inst     = inst_q;
  assign pc4      = pc4_q;
  assign if_valid = valid_q;
  assign if_pc    = pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    hbuf_d  = hbuf_q;
    hpc4_d  = hpc4_q;
    rpc_d   = rpc_q;

    if (pcsrc) begin
      // Redirect wins over stall and every state; always issues a bubble.
      inst_d  = NOP;
      valid_d = 1'b0;
      hbuf_d  = NOP;
      unique case (state_q)
        RUN: begin
          if (hs) begin
            pc_d = baddr;
          end else begin
            // Request still pending: keep address stable, remember target.
            rpc_d   = baddr;
            state_d = DROP;
          end
        end
        HOLD: begin
          pc_d    = baddr;
          state_d = RUN;
        end
        DROP: begin
          rpc_d = baddr;
          if (hs) begin
            pc_d    = baddr;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end else begin
      unique case (state_q)
        RUN: begin
          if (hs) begin
            pc_d = pc_plus4;
            if (stall) begin
              hbuf_d  = imem_rdata;
              hpc4_d  = pc_plus4;
              state_d = HOLD;
            end else begin
              inst_d  = imem_rdata;
              pc4_d   = pc_plus4;
              valid_d = 1'b1;
            end
          end else if (!stall) begin
            inst_d  = NOP;
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            inst_d  = hbuf_q;
            pc4_d   = hpc4_q;
            valid_d = 1'b1;
            state_d = RUN;
          end
        end
        DROP: begin
          // Stale word is discarded; bubbles continue until it returns.
          if (!stall) begin
            inst_d  = NOP;
            valid_d = 1'b0;
          end
          if (hs) begin
            pc_d    = rpc_q;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      inst_q  <= NOP;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      hbuf_q  <= NOP;
      hpc4_q  <= 32'd0;
      rpc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      hbuf_q  <= hbuf_d;
      hpc4_q  <= hpc4_d;
      rpc_q   <= rpc_d;
    end
  end

endmodule

// File: tb/tb_stage1_if.sv
// tb_stage1_if: directed plus randomized checking of stage1_if against a
// behavioural fetch model (memory returns addr|1). A second instance with
// RESET_PC near the top of the address space checks PC wrap.
module tb_stage1_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        pcsrc = 1'b0;
  logic [31:0] baddr = 32'd0;
  logic        imem_ready = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] pc4;
  logic        if_valid;
  logic [31:0] if_pc;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_inst;
  logic [31:0] w_pc4;
  logic        w_valid;
  logic [31:0] w_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr | 32'h1;

  stage1_if u_dut (
    .clk(clk), .rst(rst), .stall(stall), .pcsrc(pcsrc), .baddr(baddr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .inst(inst), .pc4(pc4), .if_valid(if_valid),
    .if_pc(if_pc)
  );

  stage1_if #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .pcsrc(1'b0), .baddr(32'd0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1),
    .imem_rdata(w_addr | 32'h1), .inst(w_inst), .pc4(w_pc4), .if_valid(w_valid),
    .if_pc(w_pc)
  );

  // Reference model: a PC, a "holding a captured word" flag and a
  // "discarding a stale request" flag with its pending target.
  logic [31:0] m_pc, m_inst, m_pc4, m_held, m_held_pc4, m_target;
  logic        m_valid, holding, discarding;

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_held = 32'h0; m_held_pc4 = 32'h0; m_target = 32'h0;
    holding = 1'b0; discarding = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic p, input logic [31:0] b, input logic r);
    logic        hs;
    logic [31:0] word;
    hs   = !holding && r;
    word = m_pc | 32'h1;
    if (p) begin
      m_inst = 32'h0; m_valid = 1'b0; m_held = 32'h0;
      if (holding || hs) begin
        m_pc = b; holding = 1'b0; discarding = 1'b0;
      end else begin
        discarding = 1'b1; m_target = b;
      end
    end else if (holding) begin
      if (!s) begin
        m_inst = m_held; m_pc4 = m_held_pc4; m_valid = 1'b1; holding = 1'b0;
      end
    end else if (discarding) begin
      if (!s) begin m_inst = 32'h0; m_valid = 1'b0; end
      if (hs) begin m_pc = m_target; discarding = 1'b0; end
    end else begin
      if (hs) begin
        if (s) begin
          m_held = word; m_held_pc4 = m_pc + 32'd4; holding = 1'b1;
        end else begin
          m_inst = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end else if (!s) begin
        m_inst = 32'h0; m_valid = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a falling edge: drive, check request side, clock,
  // advance the model, check IF/ID registers.
  task automatic cyc(input logic s, input logic p, input logic [31:0] b, input logic r);
    stall = s; pcsrc = p; baddr = b; imem_ready = r;
    #1;
    chk("imem_req", 32'(imem_req), 32'(!holding));
    chk("imem_addr", imem_addr, m_pc);
    chk("if_pc", if_pc, m_pc);
    @(posedge clk);
    #1;
    model_step(s, p, b, r);
    chk("inst", inst, m_inst);
    chk("pc4", pc4, m_pc4);
    chk("if_valid", 32'(if_valid), 32'(m_valid));
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc4", pc4, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    rst = 1'b0;

    // Zero-wait stream; wrap instance checked on its first edge.
    cyc(0, 0, 0, 1);
    chk("stream_inst0", inst, 32'h1);
    chk("wrap_pc4", w_pc4, 32'h0);
    chk("wrap_inst", w_inst, 32'hFFFF_FFFD);
    chk("wrap_next_addr", w_addr, 32'h0);
    cyc(0, 0, 0, 1);
    chk("stream_inst1", inst, 32'h5);
    cyc(0, 0, 0, 1);
    chk("stream_inst2", inst, 32'h9);
    chk("stream_pc4_2", pc4, 32'hC);

    // Two wait states on the fetch of 0xC.
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("wait_addr", imem_addr, 32'hC);
    cyc(0, 0, 0, 1);
    chk("wait_inst", inst, 32'hD);

    // Stall capture at PC=0x10 for three cycles.
    cyc(1, 0, 0, 1);
    chk("stall_req_drop", 32'(imem_req), 32'h0);
    chk("stall_inst_hold", inst, 32'hD);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("unstall_inst", inst, 32'h11);
    chk("unstall_pc4", pc4, 32'h14);
    cyc(0, 0, 0, 1);
    chk("unstall_next", inst, 32'h15);

    // Advance to PC=0x20, redirect on a handshake.
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("pre_redir_pc", if_pc, 32'h20);
    cyc(0, 1, 32'h100, 1);
    chk("redir_bubble", 32'(if_valid), 32'h0);
    chk("redir_addr", imem_addr, 32'h100);
    cyc(0, 0, 0, 1);
    chk("redir_inst", inst, 32'h101);
    chk("redir_pc4", pc4, 32'h104);

    // Redirect while the 0x30 fetch is pending.
    cyc(0, 1, 32'h30, 1);
    cyc(0, 1, 32'h200, 0);
    cyc(0, 0, 0, 0);
    chk("drop_addr", imem_addr, 32'h30);
    cyc(0, 0, 0, 1);
    chk("drop_no_stale", 32'(if_valid), 32'h0);
    chk("drop_next_addr", imem_addr, 32'h200);
    cyc(0, 0, 0, 1);
    chk("drop_inst", inst, 32'h201);

    // Same with stall high during the redirect.
    cyc(0, 0, 0, 0);
    cyc(1, 1, 32'h300, 0);
    chk("drop_stall_bubble", 32'(if_valid), 32'h0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("drop_stall_addr", imem_addr, 32'h300);
    cyc(0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
          $urandom, ($urandom_range(0, 2) != 0));
    end

    // Reset asserted asynchronously while holding a captured word.
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("hold_entered", 32'(imem_req), 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_inst", inst, 32'h0);
    chk("arst_pc4", pc4, 32'h0);
    chk("arst_valid", 32'(if_valid), 32'h0);
    chk("arst_req", 32'(imem_req), 32'h0);
    chk("arst_pc", if_pc, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 1);
    chk("restart_inst", inst, 32'h1);
    cyc(0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
